// File: rtl/spi_defs_pkg.sv
`default_nettype none
// ============================================================
// Package : spi_defs
// Purpose : Shared types and constants for the SPI controller.
// Rev     : 1.0
// ============================================================
package spi_defs;

   localparam int CHAR_BITS = 8;
   localparam int CFG_DIV_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      CS_SETUP = 3'd2,
      TRANSFER = 3'd3,
      CS_HOLD  = 3'd4
   } spi_ctrl_state_e;

   typedef struct packed {
      logic                 cpol;
      logic                 cpha;
      logic [CFG_DIV_W-1:0] div;
   } spi_cfg_t;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================
// Module  : spi_sclk_gen
// Purpose : SCLK divider, edge counter and edge-type qualifiers.
// Rev     : 1.0
// ============================================================
module spi_sclk_gen #(
   parameter int DIV_W     = 8,
   parameter int CHAR_BITS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             count_en,
   input  logic             shift_en,
   input  logic             idle_level,
   input  logic [DIV_W-1:0] div,
   output logic             sclk,
   output logic             tc,
   output logic             first,
   output logic             lead,
   output logic             trail,
   output logic             last
);

   localparam int c_edge_w = $clog2(2 * CHAR_BITS);
   localparam logic [c_edge_w-1:0] c_last_edge = c_edge_w'(2 * CHAR_BITS - 1);

   logic [DIV_W-1:0]    r_div_cnt;
   logic [c_edge_w-1:0] r_edge_cnt;
   logic                r_sclk;
   logic                w_tc;

   assign w_tc  = count_en && (r_div_cnt == div);
   assign tc    = w_tc;
   assign first = count_en && (r_div_cnt == '0);
   assign lead  = w_tc && shift_en && !r_edge_cnt[0];
   assign trail = w_tc && shift_en &&  r_edge_cnt[0];
   assign last  = (r_edge_cnt == c_last_edge);
   assign sclk  = r_sclk;

   // The divider also times CS setup/hold; SCLK only moves while shifting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt  <= '0;
         r_edge_cnt <= '0;
         r_sclk     <= 1'b0;
      end else begin
         if (!count_en || w_tc) begin
            r_div_cnt <= '0;
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end
         if (!shift_en) begin
            r_edge_cnt <= '0;
            r_sclk     <= idle_level;
         end else if (w_tc) begin
            r_edge_cnt <= r_edge_cnt + c_edge_w'(1);
            r_sclk     <= ~r_sclk;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_ctrl_fsm.sv
`default_nettype none
// ============================================================
// Module  : spi_ctrl_fsm
// Purpose : SPI transfer controller: SCLK, CS_n and datapath strobes.
// Rev     : 1.0
// ============================================================
module spi_ctrl_fsm #(
   parameter int DIV_W     = 8,
   parameter int CHAR_BITS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spi_en_i,
   input  logic             cpol_i,
   input  logic             cpha_i,
   input  logic [DIV_W-1:0] clk_div_i,
   input  logic             tx_fifo_empty_i,
   output logic             sclk_o,
   output logic             cs_n_o,
   output logic             tx_shift_load_o,
   output logic             tx_fifo_read_o,
   output logic             mosi_first_en_o,
   output logic             mosi_transmit_en_o,
   output logic             miso_en_o,
   output logic             mosi_mux_sel_o,
   output logic             rx_fifo_write_o,
   output logic             busy_o,
   output logic             xfer_done_o
);

   import spi_defs::*;

   spi_ctrl_state_e r_state;
   spi_ctrl_state_e w_state_nxt;
   spi_cfg_t        r_cfg;

   logic w_count_en;
   logic w_shift_en;
   logic w_idle_level;
   logic w_tc;
   logic w_first;
   logic w_lead;
   logic w_trail;
   logic w_last;

   assign w_count_en   = (r_state == CS_SETUP) || (r_state == TRANSFER) || (r_state == CS_HOLD);
   assign w_shift_en   = (r_state == TRANSFER);
   // Follow the incoming polarity during LOAD so SCLK is settled before CS falls.
   assign w_idle_level = (r_state == LOAD) ? cpol_i : r_cfg.cpol;
   assign busy_o       = (r_state != IDLE);

   spi_sclk_gen #(
      .DIV_W     (DIV_W),
      .CHAR_BITS (CHAR_BITS)
   ) u_sclk_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_en   (w_count_en),
      .shift_en   (w_shift_en),
      .idle_level (w_idle_level),
      .div        (r_cfg.div[DIV_W-1:0]),
      .sclk       (sclk_o),
      .tc         (w_tc),
      .first      (w_first),
      .lead       (w_lead),
      .trail      (w_trail),
      .last       (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cfg   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == LOAD) begin
            r_cfg.cpol <= cpol_i;
            r_cfg.cpha <= cpha_i;
            r_cfg.div  <= CFG_DIV_W'(clk_div_i);
         end
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      cs_n_o             = 1'b1;
      mosi_mux_sel_o     = 1'b0;
      tx_shift_load_o    = 1'b0;
      tx_fifo_read_o     = 1'b0;
      mosi_first_en_o    = 1'b0;
      mosi_transmit_en_o = 1'b0;
      miso_en_o          = 1'b0;
      rx_fifo_write_o    = 1'b0;
      xfer_done_o        = 1'b0;
      case (r_state)
         IDLE: begin
            if (spi_en_i && !tx_fifo_empty_i) begin
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            tx_shift_load_o = 1'b1;
            tx_fifo_read_o  = 1'b1;
            w_state_nxt     = CS_SETUP;
         end
         CS_SETUP: begin
            cs_n_o          = 1'b0;
            mosi_mux_sel_o  = 1'b1;
            mosi_first_en_o = !r_cfg.cpha && w_first;
            if (w_tc) begin
               w_state_nxt = TRANSFER;
            end
         end
         TRANSFER: begin
            cs_n_o         = 1'b0;
            mosi_mux_sel_o = 1'b1;
            // With CPHA=0 the first bit was presented during setup, so edge 15 shifts nothing.
            if (r_cfg.cpha) begin
               mosi_transmit_en_o = w_lead;
               miso_en_o          = w_trail;
            end else begin
               miso_en_o          = w_lead;
               mosi_transmit_en_o = w_trail && !w_last;
            end
            if (w_trail && w_last) begin
               w_state_nxt = CS_HOLD;
            end
         end
         CS_HOLD: begin
            cs_n_o          = 1'b0;
            mosi_mux_sel_o  = 1'b1;
            rx_fifo_write_o = w_first;
            xfer_done_o     = w_first;
            if (w_tc) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_ctrl_fsm.sv
`default_nettype none
// ============================================================
// Module  : tb_spi_ctrl_fsm
// Purpose : Directed self-checking bench for spi_ctrl_fsm with a datapath model.
// Rev     : 1.0
// ============================================================
module tb_spi_ctrl_fsm;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       spi_en  = 1'b0;
   logic       cpol    = 1'b0;
   logic       cpha    = 1'b0;
   logic [7:0] clk_div = 8'd0;
   logic       tx_fifo_empty;

   logic sclk, cs_n, tx_shift_load, tx_fifo_read, mosi_first_en, mosi_transmit_en;
   logic miso_en, mosi_mux_sel, rx_fifo_write, busy, xfer_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_ctrl_fsm #(.DIV_W(8), .CHAR_BITS(8)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .spi_en_i           (spi_en),
      .cpol_i             (cpol),
      .cpha_i             (cpha),
      .clk_div_i          (clk_div),
      .tx_fifo_empty_i    (tx_fifo_empty),
      .sclk_o             (sclk),
      .cs_n_o             (cs_n),
      .tx_shift_load_o    (tx_shift_load),
      .tx_fifo_read_o     (tx_fifo_read),
      .mosi_first_en_o    (mosi_first_en),
      .mosi_transmit_en_o (mosi_transmit_en),
      .miso_en_o          (miso_en),
      .mosi_mux_sel_o     (mosi_mux_sel),
      .rx_fifo_write_o    (rx_fifo_write),
      .busy_o             (busy),
      .xfer_done_o        (xfer_done)
   );

   // Datapath, FIFOs and slave model
   logic [7:0] tx_mem [0:15];
   logic [7:0] rx_mem [0:15];
   int wr_idx = 0;
   int rd_idx = 0;
   assign tx_fifo_empty = (wr_idx == rd_idx);

   logic       lsb_first    = 1'b0;
   logic       loopback     = 1'b1;
   logic [7:0] slave_tx_val = 8'h00;
   logic [7:0] sr = 8'h00, slave_sr = 8'h00, rx_sr = 8'h00, slave_rx = 8'h00;
   logic       mosi_out = 1'b0, slave_out = 1'b0;
   logic       prev_sclk = 1'b0, prev_cs_n = 1'b1;
   wire        mosi_line = mosi_mux_sel ? mosi_out : 1'b0;
   wire        miso_line = loopback ? mosi_line : slave_out;

   int n_rxw = 0, n_load = 0, n_first = 0, n_mtx = 0, n_miso = 0, n_done = 0;
   int n_edges = 0, n_busy = 0;
   int cs_low_run = 0, cs_high_run = 0, last_cs_low = 0, last_cs_high = 0;
   int since_tog = 0, last_half = 0;

   always @(negedge clk) begin
      if (tx_shift_load) begin
         sr       <= tx_mem[rd_idx % 16];
         slave_sr <= slave_tx_val;
         n_load   <= n_load + 1;
      end
      if (tx_fifo_read) rd_idx <= rd_idx + 1;
      if (mosi_first_en || mosi_transmit_en) begin
         mosi_out  <= lsb_first ? sr[0] : sr[7];
         sr        <= lsb_first ? (sr >> 1) : (sr << 1);
         slave_out <= lsb_first ? slave_sr[0] : slave_sr[7];
         slave_sr  <= lsb_first ? (slave_sr >> 1) : (slave_sr << 1);
      end
      if (mosi_first_en)    n_first <= n_first + 1;
      if (mosi_transmit_en) n_mtx   <= n_mtx + 1;
      if (miso_en) begin
         rx_sr    <= lsb_first ? {miso_line, rx_sr[7:1]} : {rx_sr[6:0], miso_line};
         slave_rx <= lsb_first ? {mosi_line, slave_rx[7:1]} : {slave_rx[6:0], mosi_line};
         n_miso   <= n_miso + 1;
      end
      if (rx_fifo_write) begin
         rx_mem[n_rxw % 16] <= rx_sr;
         n_rxw <= n_rxw + 1;
      end
      if (xfer_done) n_done <= n_done + 1;
      if (busy)      n_busy <= n_busy + 1;
      if (rst_n && (sclk != prev_sclk) && !prev_cs_n) begin
         n_edges   <= n_edges + 1;
         last_half <= since_tog;
         since_tog <= 1;
      end else begin
         since_tog <= since_tog + 1;
      end
      if (cs_n) begin
         cs_high_run <= cs_high_run + 1;
         cs_low_run  <= 0;
         if (!prev_cs_n) last_cs_low <= cs_low_run;
      end else begin
         cs_low_run  <= cs_low_run + 1;
         cs_high_run <= 0;
         if (prev_cs_n) last_cs_high <= cs_high_run;
      end
      prev_sclk <= sclk;
      prev_cs_n <= cs_n;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] b);
      tx_mem[wr_idx % 16] = b;
      wr_idx = wr_idx + 1;
   endtask

   // Waits until the RX write count reaches target and the FSM is idle.
   task automatic wait_rx(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (n_rxw >= target && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
      total++; if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", sclk); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++;
      if ({tx_shift_load, tx_fifo_read, mosi_first_en, mosi_transmit_en, miso_en,
           mosi_mux_sel, rx_fifo_write, xfer_done} !== 8'h00) begin
         bad++;
         $display("FAIL reset_strobes: got %b want 00000000",
                  {tx_shift_load, tx_fifo_read, mosi_first_en, mosi_transmit_en, miso_en,
                   mosi_mux_sel, rx_fifo_write, xfer_done});
      end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_mode0();
      bit ok;
      int r0 = n_rxw, e0 = n_edges, d0 = n_done, m0 = n_miso, t0 = n_mtx, f0 = n_first, b0 = n_busy;
      lsb_first = 1'b0; loopback = 1'b1;
      cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
      push_tx(8'hA5);
      spi_en = 1'b1;
      wait_rx(r0 + 1, 200, ok);
      spi_en = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL m0_timeout: got no rx write want 1"); end
      total++; if (rx_mem[r0 % 16] !== 8'hA5) begin bad++; $display("FAIL m0_rx: got %h want a5", rx_mem[r0 % 16]); end
      total++; if (n_edges - e0 != 16) begin bad++; $display("FAIL m0_edges: got %0d want 16", n_edges - e0); end
      total++; if (last_cs_low != 18) begin bad++; $display("FAIL m0_cs_low: got %0d want 18", last_cs_low); end
      total++; if (n_done - d0 != 1) begin bad++; $display("FAIL m0_done: got %0d want 1", n_done - d0); end
      total++; if (n_miso - m0 != 8) begin bad++; $display("FAIL m0_miso_en: got %0d want 8", n_miso - m0); end
      total++; if (n_mtx - t0 != 7) begin bad++; $display("FAIL m0_mosi_tx: got %0d want 7", n_mtx - t0); end
      total++; if (n_first - f0 != 1) begin bad++; $display("FAIL m0_first: got %0d want 1", n_first - f0); end
      total++; if (n_busy - b0 != 19) begin bad++; $display("FAIL m0_busy_len: got %0d want 19", n_busy - b0); end
   endtask

   task automatic test_mode3();
      bit ok;
      int r0 = n_rxw, e0 = n_edges, t0 = n_mtx, f0 = n_first, b0 = n_busy;
      lsb_first = 1'b1; loopback = 1'b0; slave_tx_val = 8'h81;
      cpol = 1'b1; cpha = 1'b1; clk_div = 8'd3;
      push_tx(8'h3C);
      spi_en = 1'b1;
      for (int i = 0; i < 50 && cs_n; i++) tick();
      clk_div = 8'd0;   // must not affect the character in flight
      wait_rx(r0 + 1, 500, ok);
      spi_en = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL m3_timeout: got no rx write want 1"); end
      total++; if (rx_mem[r0 % 16] !== 8'h81) begin bad++; $display("FAIL m3_rx: got %h want 81", rx_mem[r0 % 16]); end
      total++; if (slave_rx !== 8'h3C) begin bad++; $display("FAIL m3_mosi: got %h want 3c", slave_rx); end
      total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_idle: got %b want 1", sclk); end
      total++; if (last_half != 4) begin bad++; $display("FAIL m3_half_period: got %0d want 4", last_half); end
      total++; if (last_cs_low != 72) begin bad++; $display("FAIL m3_cs_low: got %0d want 72", last_cs_low); end
      total++; if (n_edges - e0 != 16) begin bad++; $display("FAIL m3_edges: got %0d want 16", n_edges - e0); end
      total++; if (n_mtx - t0 != 8) begin bad++; $display("FAIL m3_mosi_tx: got %0d want 8", n_mtx - t0); end
      total++; if (n_first - f0 != 0) begin bad++; $display("FAIL m3_first: got %0d want 0", n_first - f0); end
      total++; if (n_busy - b0 != 73) begin bad++; $display("FAIL m3_busy_len: got %0d want 73", n_busy - b0); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int r0 = n_rxw, d0 = n_done, l0 = n_load;
      lsb_first = 1'b0; loopback = 1'b1;
      cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
      push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
      spi_en = 1'b1;
      wait_rx(r0 + 3, 300, ok);
      spi_en = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got %0d rx writes want 3", n_rxw - r0); end
      for (int k = 0; k < 3; k++) begin
         logic [7:0] exp_b;
         exp_b = 8'(k + 1);
         total++;
         if (rx_mem[(r0 + k) % 16] !== exp_b) begin
            bad++; $display("FAIL b2b_rx%0d: got %h want %h", k, rx_mem[(r0 + k) % 16], exp_b);
         end
      end
      total++; if (last_cs_high != 2) begin bad++; $display("FAIL b2b_cs_gap: got %0d want 2", last_cs_high); end
      total++; if (n_done - d0 != 3) begin bad++; $display("FAIL b2b_done: got %0d want 3", n_done - d0); end
      total++; if (n_load - l0 != 3) begin bad++; $display("FAIL b2b_loads: got %0d want 3", n_load - l0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_fifo_empty();
      int l0 = n_load, e0 = n_edges, m0 = n_miso;
      spi_en = 1'b1;
      repeat (20) tick();
      total++; if (n_load - l0 != 0) begin bad++; $display("FAIL empty_loads: got %0d want 0", n_load - l0); end
      total++; if (n_edges - e0 != 0 || n_miso - m0 != 0) begin
         bad++; $display("FAIL empty_activity: got edges=%0d miso=%0d want 0", n_edges - e0, n_miso - m0);
      end
      total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL empty_cs_n: got %b want 1", cs_n); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_busy: got %b want 0", busy); end
      spi_en = 1'b0;
   endtask

   task automatic test_en_drop();
      bit ok;
      int r0 = n_rxw, l0 = n_load, e0 = n_edges;
      lsb_first = 1'b0; loopback = 1'b1;
      cpol = 1'b0; cpha = 1'b1; clk_div = 8'd1;
      push_tx(8'h5A); push_tx(8'h96);
      spi_en = 1'b1;
      for (int i = 0; i < 200 && (n_edges - e0) < 5; i++) tick();
      spi_en = 1'b0;
      wait_rx(r0 + 1, 300, ok);
      repeat (30) tick();
      total++; if (!ok) begin bad++; $display("FAIL drop_timeout: got no rx write want 1"); end
      total++; if (n_rxw - r0 != 1) begin bad++; $display("FAIL drop_rx_writes: got %0d want 1", n_rxw - r0); end
      total++; if (rx_mem[r0 % 16] !== 8'h5A) begin bad++; $display("FAIL drop_rx: got %h want 5a", rx_mem[r0 % 16]); end
      total++; if (n_load - l0 != 1) begin bad++; $display("FAIL drop_loads: got %0d want 1", n_load - l0); end
      total++; if (busy !== 1'b0 || cs_n !== 1'b1) begin
         bad++; $display("FAIL drop_idle: got busy=%b cs_n=%b want 0/1", busy, cs_n);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int r0 = n_rxw, d0 = n_done, e0;
      lsb_first = 1'b0; loopback = 1'b1;
      cpol = 1'b0; cpha = 1'b0; clk_div = 8'd2;
      e0 = n_edges;
      spi_en = 1'b1;   // picks up the byte left over from the previous test
      for (int i = 0; i < 300 && (n_edges - e0) < 9; i++) tick();
      rst_n = 1'b0;
      #1;
      total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL rstmid_cs_n: got %b want 1", cs_n); end
      total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rstmid_sclk: got %b want 0", sclk); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      repeat (5) tick();
      total++; if (n_rxw - r0 != 0 || n_done - d0 != 0) begin
         bad++; $display("FAIL rstmid_rx_write: got writes=%0d done=%0d want 0", n_rxw - r0, n_done - d0);
      end
      spi_en = 1'b0;
      rst_n  = 1'b1;
      repeat (2) tick();
      r0 = n_rxw;
      e0 = n_edges;
      cpol = 1'b1; cpha = 1'b0; clk_div = 8'd1;
      push_tx(8'hC3);
      spi_en = 1'b1;
      wait_rx(r0 + 1, 300, ok);
      spi_en = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL rst_m2_timeout: got no rx write want 1"); end
      total++; if (rx_mem[r0 % 16] !== 8'hC3) begin bad++; $display("FAIL rst_m2_rx: got %h want c3", rx_mem[r0 % 16]); end
      total++; if (n_edges - e0 != 16) begin bad++; $display("FAIL rst_m2_edges: got %0d want 16", n_edges - e0); end
      total++; if (sclk !== 1'b1) begin bad++; $display("FAIL rst_m2_sclk_idle: got %b want 1", sclk); end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3();
      test_back_to_back();
      test_fifo_empty();
      test_en_drop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion want finish before 400000ns");
      $fatal(1);
   end

endmodule
`default_nettype wire
